fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_pkg.sv | 17 +
 rtl/rr_pick.sv | 33 +++
 rtl/fifo_wr_arbiter.sv | 105 ++++++++++
 tb/tb_fifo_wr_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO write-port arbiter: default sizes and FSM state encoding.
package fifo_pkg;

  localparam int unsigned NREQ_DEFAULT   = 4;
  localparam int unsigned DATA_W_DEFAULT = 8;

  typedef enum logic {
    StIdle = 1'b0,
    StOwn  = 1'b1
  } arb_state_e;

  // Index width for a requester count; keeps a 1-requester build legal.
  function automatic int unsigned idx_w(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit searching from last_owner+1, wrapping.
module rr_pick
  import fifo_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEFAULT,
  localparam int unsigned IDX_W = idx_w(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last_owner,
  output logic             valid,
  output logic [IDX_W-1:0] index
);

  function automatic logic [IDX_W-1:0] wrap(logic [IDX_W-1:0] base, int unsigned off);
    int unsigned j;
    j = 32'(base) + off;
    if (j >= NREQ) j = j - NREQ;
    return IDX_W'(j);
  endfunction

  // Scan from the farthest slot down so the nearest set bit is the last assignment.
  always_comb begin
    valid = 1'b0;
    index = '0;
    for (int unsigned k = NREQ; k >= 1; k--) begin
      if (req[wrap(last_owner, k)]) begin
        valid = 1'b1;
        index = wrap(last_owner, k);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ requesters, with bounded bursts
// and stall-safe ownership while the FIFO is full.
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int unsigned NREQ      = NREQ_DEFAULT,
  parameter int unsigned DATA_W    = DATA_W_DEFAULT,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                     wr_clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  input  logic                     fifo_full,
  output logic [NREQ-1:0]          ack,
  output logic [NREQ-1:0]          grant,
  output logic                     fifo_wr_en,
  output logic [DATA_W-1:0]        fifo_write_data,
  output logic                     busy
);

  localparam int unsigned IDX_W = idx_w(NREQ);

  arb_state_e       state_q;
  logic [IDX_W-1:0] owner_q;
  logic [IDX_W-1:0] last_owner_q;
  logic [NREQ-1:0]  grant_q;
  logic [3:0]       burst_q;

  logic             pick_valid;
  logic [IDX_W-1:0] pick_index;
  logic             own_req;
  logic             accept;
  logic [3:0]       burst_inc;
  logic             burst_done;

  rr_pick #(
    .NREQ(NREQ)
  ) u_rr_pick (
    .req       (req),
    .last_owner(last_owner_q),
    .valid     (pick_valid),
    .index     (pick_index)
  );

  // grant_q is one-hot of owner_q, so masking with it selects the owner's request.
  always_comb begin
    own_req    = |(req & grant_q);
    accept     = (state_q == StOwn) && own_req && !fifo_full;
    burst_inc  = burst_q + 4'd1;
    burst_done = (burst_inc == 4'(MAX_BURST));
  end

  always_ff @(posedge wr_clk) begin
    if (rst) begin
      state_q      <= StIdle;
      owner_q      <= '0;
      last_owner_q <= IDX_W'(NREQ - 1);
      grant_q      <= '0;
      burst_q      <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (pick_valid) begin
            state_q <= StOwn;
            owner_q <= pick_index;
            grant_q <= NREQ'(1) << pick_index;
            burst_q <= '0;
          end
        end
        StOwn: begin
          if (!own_req || (accept && burst_done)) begin
            state_q      <= StIdle;
            grant_q      <= '0;
            last_owner_q <= owner_q;
          end else if (accept) begin
            burst_q <= burst_inc;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Outputs are forced quiet while rst is high so a reset mid-burst drops that cycle's write.
  always_comb begin
    ack             = '0;
    fifo_wr_en      = 1'b0;
    fifo_write_data = '0;
    busy            = 1'b0;
    if (!rst && (state_q == StOwn)) begin
      busy       = 1'b1;
      fifo_wr_en = accept;
      ack        = accept ? grant_q : '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (grant_q[i]) begin
          fifo_write_data = fifo_write_data | req_data[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  assign grant = grant_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: directed scenarios plus a long randomized run with a
// fairness bound on waiting requesters.
module tb_fifo_wr_arbiter;

  localparam int NREQ      = 4;
  localparam int DATA_W    = 8;
  localparam int MAX_BURST = 4;
  localparam int BOUND     = (NREQ - 1) * (MAX_BURST + 1) + 1;

  logic                   wr_clk = 1'b0;
  logic                   rst = 1'b1;
  logic [NREQ-1:0]        req = '0;
  logic [NREQ*DATA_W-1:0] req_data = '0;
  logic                   fifo_full = 1'b0;
  logic [NREQ-1:0]        ack;
  logic [NREQ-1:0]        grant;
  logic                   fifo_wr_en;
  logic [DATA_W-1:0]      fifo_write_data;
  logic                   busy;

  always #5 wr_clk = ~wr_clk;

  fifo_wr_arbiter #(
    .NREQ     (NREQ),
    .DATA_W   (DATA_W),
    .MAX_BURST(MAX_BURST)
  ) dut (
    .wr_clk         (wr_clk),
    .rst            (rst),
    .req            (req),
    .req_data       (req_data),
    .fifo_full      (fifo_full),
    .ack            (ack),
    .grant          (grant),
    .fifo_wr_en     (fifo_wr_en),
    .fifo_write_data(fifo_write_data),
    .busy           (busy)
  );

  typedef struct {
    int                cyc;
    logic [NREQ-1:0]   grant;
    logic              busy;
    logic              wr_en;
    logic [DATA_W-1:0] data;
  } st_t;

  typedef struct {
    logic [NREQ-1:0]   ack;
    logic [DATA_W-1:0] data;
  } wr_t;

  st_t st_q[$];
  wr_t wr_q[$];
  int  wr_log[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  bit  started = 0;
  bit  fair_en = 0;
  bit  rand_mode = 0;
  int  wait_c[NREQ];
  int  max_wait[NREQ];

  // Per-requester pending words; req is high while a word is pending.
  logic [DATA_W-1:0] ring[NREQ][16];
  int                head[NREQ];
  int                cnt[NREQ];

  // Reference model: who owns the port, who owned it last, writes in this grant.
  int              m_owner = -1;
  int              m_last = NREQ - 1;
  int              m_cnt = 0;
  logic [NREQ-1:0] p_req = '0;
  logic            p_full = 1'b0;
  logic            p_rst = 1'b1;
  int              p_wr = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic push_word(input int i, input logic [DATA_W-1:0] d);
    ring[i][(head[i] + cnt[i]) % 16] = d;
    cnt[i]++;
  endtask

  task automatic step(input bit full, input bit r);
    st_t st;
    wr_t w;
    bit  wr;
    @(posedge wr_clk);
    #1;
    if (p_wr >= 0) begin
      head[p_wr] = (head[p_wr] + 1) % 16;
      cnt[p_wr]--;
    end
    if (p_rst) begin
      m_owner = -1;
      m_last  = NREQ - 1;
      m_cnt   = 0;
    end else if (m_owner < 0) begin
      for (int k = 1; k <= NREQ; k++) begin
        int j = (m_last + k) % NREQ;
        if (p_req[j]) begin
          m_owner = j;
          m_cnt   = 0;
          break;
        end
      end
    end else if (!p_req[m_owner]) begin
      m_last  = m_owner;
      m_owner = -1;
    end else if (!p_full) begin
      m_cnt++;
      if (m_cnt == MAX_BURST) begin
        m_last  = m_owner;
        m_owner = -1;
      end
    end
    if (rand_mode) begin
      for (int i = 0; i < NREQ; i++) begin
        if (cnt[i] == 0 && $urandom_range(3) == 0) begin
          repeat ($urandom_range(6, 1)) push_word(i, DATA_W'($urandom));
        end
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      req[i] = (cnt[i] != 0);
      req_data[i*DATA_W +: DATA_W] = (cnt[i] != 0) ? ring[i][head[i]] : '0;
    end
    fifo_full = full;
    rst       = r;
    wr        = (m_owner >= 0) && !r && req[m_owner] && !full;
    st.cyc    = cyc;
    st.grant  = (m_owner >= 0) ? NREQ'(1) << m_owner : '0;
    st.busy   = (m_owner >= 0) && !r;
    st.wr_en  = wr;
    st.data   = ((m_owner >= 0) && !r) ? req_data[m_owner*DATA_W +: DATA_W] : '0;
    st_q.push_back(st);
    if (wr) begin
      w.ack  = NREQ'(1) << m_owner;
      w.data = st.data;
      wr_q.push_back(w);
    end
    p_wr    = wr ? m_owner : -1;
    p_req   = req;
    p_full  = full;
    p_rst   = r;
    started = 1;
    cyc++;
  endtask

  task automatic do_reset();
    for (int i = 0; i < NREQ; i++) begin
      head[i] = 0;
      cnt[i]  = 0;
    end
    p_wr = -1;
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
  endtask

  task automatic drain(input int limit);
    int left;
    for (int n = 0; n < limit; n++) begin
      left = 0;
      for (int i = 0; i < NREQ; i++) left += cnt[i];
      if (left == 0 && p_wr < 0) break;
      step(1'b0, 1'b0);
    end
    left = 0;
    for (int i = 0; i < NREQ; i++) left += cnt[i];
    check("drain_words_left", left, 0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
  endtask

  // Monitor: every cycle compare status, and pop the write scoreboard on each DUT write.
  initial begin
    st_t st;
    wr_t w;
    forever begin
      @(negedge wr_clk);
      if (started) begin
        if (st_q.size() == 0) begin
          errors++;
          $display("FAIL status_queue cyc=%0d actual=empty required=entry", cyc);
        end else begin
          st = st_q.pop_front();
          check("grant", grant, st.grant);
          check("busy", busy, st.busy);
          check("fifo_wr_en", fifo_wr_en, st.wr_en);
          if (!st.wr_en) begin
            check("idle_data", fifo_write_data, st.data);
            check("idle_ack", ack, 0);
          end
        end
        if (fifo_wr_en) begin
          wr_log.push_back(st.cyc);
          if (wr_q.size() == 0) begin
            errors++;
            $display("FAIL write_queue cyc=%0d actual=write required=none", cyc);
          end else begin
            w = wr_q.pop_front();
            check("ack", ack, w.ack);
            check("write_data", fifo_write_data, w.data);
          end
        end
        if (fair_en) begin
          for (int i = 0; i < NREQ; i++) begin
            if (!req[i] || grant[i]) wait_c[i] = 0;
            else if (!fifo_full) wait_c[i]++;
            if (wait_c[i] > max_wait[i]) max_wait[i] = wait_c[i];
          end
        end
      end
    end
  end

  initial begin
    int s;
    int exp_cyc[6];
    for (int i = 0; i < NREQ; i++) begin
      wait_c[i]   = 0;
      max_wait[i] = 0;
    end

    // Single requester: bursts of 4 with one idle cycle between.
    do_reset();
    for (int k = 0; k < 6; k++) push_word(0, 8'hA0 + 8'(k));
    s = cyc;
    wr_log.delete();
    drain(40);
    exp_cyc = '{s + 1, s + 2, s + 3, s + 4, s + 6, s + 7};
    check("single_write_count", wr_log.size(), 6);
    for (int k = 0; k < 6 && k < wr_log.size(); k++) check("single_write_cycle", wr_log[k], exp_cyc[k]);

    // Contention among all four requesters.
    do_reset();
    for (int i = 0; i < NREQ; i++)
      for (int k = 0; k < 8; k++) push_word(i, 8'(i * 16 + k));
    drain(100);

    // Full stall after the first write of requester 2.
    do_reset();
    for (int k = 0; k < 4; k++) push_word(2, 8'hC0 + 8'(k));
    push_word(3, 8'hD0);
    push_word(3, 8'hD1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    repeat (5) step(1'b1, 1'b0);
    drain(40);

    // Early release by requester 1 hands over to requester 3.
    do_reset();
    push_word(1, 8'h11);
    push_word(1, 8'h12);
    push_word(3, 8'h31);
    push_word(3, 8'h32);
    drain(40);

    // Reset during requester 3's second write.
    do_reset();
    for (int k = 0; k < 3; k++) push_word(3, 8'h30 + 8'(k));
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    push_word(0, 8'h50);
    push_word(0, 8'h51);
    step(1'b0, 1'b1);
    drain(40);

    // Randomized traffic with random full.
    do_reset();
    rand_mode = 1;
    fair_en   = 1;
    repeat (10000) step($urandom_range(4) == 0, 1'b0);
    rand_mode = 0;
    fair_en   = 0;
    drain(200);

    for (int i = 0; i < NREQ; i++) begin
      checks++;
      if (max_wait[i] > BOUND) begin
        errors++;
        $display("FAIL fairness req%0d actual_wait=%0d required_max=%0d", i, max_wait[i], BOUND);
      end
    end

    @(negedge wr_clk);
    #1;
    check("write_queue_empty", wr_q.size(), 0);
    check("status_queue_empty", st_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
